// File: rtl/mult_div_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
//   md_op_e    : operation code carried on op_i
//   md_state_e : sequencer states
//   helpers    : operation classification
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's complement negate.
//   neg_i : negate when high
//   val_i : input value, W bits
//   res_o : val_i or -val_i
module mult_div_unit_sign_fix #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? ((~val_i) + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division on operand
// magnitudes, followed by one sign-correction cycle. Fixed 33-edge latency.
//   clk_i, rst_ni      : clock, async active-low reset
//   start_i, op_i      : launch operation (sampled only in IDLE)
//   a_i, b_i           : rs / rt operands
//   mthi_i, mtlo_i     : write a_i into HI / LO (aborts a running operation)
//   hilo_read_i        : MFHI/MFLO decoded in ID
//   hi_o, lo_o         : HI/LO registers
//   busy_o, done_o     : operation in flight / one-cycle completion pulse
//   stall_o            : pipeline hold request
//
// state | meaning
// IDLE  | waiting; accepts start or HI/LO writes
// CALC  | one shift-add / restoring-divide iteration per edge
// FIX   | sign correction and HI/LO update
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic             hilo_read_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o
);

    localparam int CNT_W = $clog2(ITERS);
    localparam int W2    = 2 * WIDTH;

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               div_q, q_sign_q, r_sign_q;
    logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic [W2-1:0]      prod_q;      // {acc, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    md_op_e             op;
    logic               wr, sgn, launch;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH+1:0]   diff;
    logic               borrow;
    logic [W2-1:0]      prod_res;
    logic [WIDTH-1:0]   quot_res, rem_res;
    logic               unused_diff;

    assign op     = md_op_e'(op_i);
    assign wr     = mthi_i | mtlo_i;
    assign sgn    = md_is_signed(op);
    assign launch = (state_q == ST_IDLE) && start_i && !wr;

    mult_div_unit_sign_fix #(.W(WIDTH)) u_abs_a (
        .neg_i(sgn & a_i[WIDTH-1]), .val_i(a_i), .res_o(a_abs));
    mult_div_unit_sign_fix #(.W(WIDTH)) u_abs_b (
        .neg_i(sgn & b_i[WIDTH-1]), .val_i(b_i), .res_o(b_abs));

    mult_div_unit_sign_fix #(.W(W2)) u_fix_prod (
        .neg_i(q_sign_q), .val_i(prod_q), .res_o(prod_res));
    mult_div_unit_sign_fix #(.W(WIDTH)) u_fix_quot (
        .neg_i(q_sign_q), .val_i(prod_q[WIDTH-1:0]), .res_o(quot_res));
    mult_div_unit_sign_fix #(.W(WIDTH)) u_fix_rem (
        .neg_i(r_sign_q), .val_i(prod_q[W2-1:WIDTH]), .res_o(rem_res));

    assign mul_sum = {1'b0, prod_q[W2-1:WIDTH]} + {1'b0, opnd_q};
    // Partial remainder after shifting in the next dividend bit.
    assign rem_sh  = prod_q[W2-1:WIDTH-1];
    assign diff    = {1'b0, rem_sh} - {2'b00, opnd_q};
    assign borrow  = diff[WIDTH+1];
    // A non-borrowing difference is below the divisor, so bit WIDTH is always zero.
    assign unused_diff = diff[WIDTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch) state_d = ST_CALC;
            ST_CALC: begin
                if (wr)                                  state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(ITERS - 1))     state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == ST_CALC) || (state_q == ST_FIX);
        stall_o = busy_o && (hilo_read_i || start_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            div_q    <= 1'b0;
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
            opnd_q   <= '0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == ST_FIX) && !wr;
            if (launch) begin
                cnt_q    <= '0;
                div_q    <= md_is_div(op);
                q_sign_q <= sgn & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                r_sign_q <= sgn & a_i[WIDTH-1];
                if (md_is_div(op)) begin
                    opnd_q <= b_abs;
                    prod_q <= {{WIDTH{1'b0}}, a_abs};
                end else begin
                    opnd_q <= a_abs;
                    prod_q <= {{WIDTH{1'b0}}, b_abs};
                end
            end else if (state_q == ST_CALC && !wr) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (div_q) begin
                    if (!borrow) prod_q <= {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                    else         prod_q <= {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
                end else begin
                    if (prod_q[0]) prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
                    else           prod_q <= {1'b0, prod_q[W2-1:1]};
                end
            end

            if (mthi_i) begin
                hi_q <= a_i;
            end else if (state_q == ST_FIX && !wr) begin
                hi_q <= div_q ? rem_res : prod_res[W2-1:WIDTH];
            end
            if (mtlo_i) begin
                lo_q <= a_i;
            end else if (state_q == ST_FIX && !wr) begin
                lo_q <= div_q ? quot_res : prod_res[WIDTH-1:0];
            end
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, mthi_i, mtlo_i, hilo_read_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic [31:0] hi_o, lo_o;
    logic        busy_o, done_o, stall_o;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi, model_lo;

    mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
        .hilo_read_i(hilo_read_i), .hi_o(hi_o), .lo_o(lo_o),
        .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued result.
    always @(negedge clk_i) begin
        if (rst_ni && done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {hi_o, lo_o}, 64'hx);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hi_lo", {hi_o, lo_o}, e);
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int restart_at, input bit rd);
        int n;
        bit stall_bad;
        exp_q.push_back({exp_hi, exp_lo});
        op_i = op; a_i = a; b_i = b; start_i = 1'b1; hilo_read_i = rd;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        a_i = ~a;
        b_i = b ^ 32'h5A5A_A5A5;
        check("busy_after_start", 64'(busy_o), 64'd1);
        stall_bad = 1'b0;
        n = 0;
        while (n < 40) begin
            n++;
            if (n == restart_at) begin
                start_i = 1'b1;
                op_i = MD_DIVU;
            end
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (rd && busy_o && !stall_o) stall_bad = 1'b1;
            if (done_o) break;
        end
        check("latency_edges", 64'(n), 64'd33);
        check("busy_after_done", 64'(busy_o), 64'd0);
        if (rd) check("stall_while_busy", 64'(stall_bad), 64'd0);
        hilo_read_i = 1'b0;
        @(posedge clk_i); #1;
        check("done_one_cycle", 64'(done_o), 64'd0);
        model_hi = exp_hi;
        model_lo = exp_lo;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 0; mthi_i = 0; mtlo_i = 0; hilo_read_i = 0;
        op_i = 2'd0; a_i = '0; b_i = '0;
        #12;
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_busy_done_stall", {61'd0, busy_o, done_o, stall_o}, 64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        run_op(MD_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        run_op(MD_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 0, 0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0, 0);
        run_op(MD_MULTU, 32'h1234_5678, 32'd9,         32'd0,         32'hA3D7_0A38, 5, 0);
        run_op(MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        0, 1);
        run_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 0);
        run_op(MD_MULT,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0, 0);

        // mtlo at E10 aborts the running operation
        op_i = MD_MULTU; a_i = 32'd3; b_i = 32'd5; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        idle_cycles(9);
        mtlo_i = 1'b1; a_i = 32'h0000_1234;
        @(posedge clk_i); #1;
        mtlo_i = 1'b0;
        check("abort_lo", 64'(lo_o), 64'h1234);
        check("abort_hi_kept", 64'(hi_o), 64'(model_hi));
        check("abort_busy", 64'(busy_o), 64'd0);
        idle_cycles(40);
        check("abort_stays_idle", 64'(busy_o), 64'd0);

        // mthi with start in IDLE: write wins, nothing launched
        op_i = MD_MULTU; a_i = 32'h0000_CAFE; b_i = 32'd2; start_i = 1'b1; mthi_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; mthi_i = 1'b0;
        check("mthi_hi", 64'(hi_o), 64'hCAFE);
        check("mthi_lo_kept", 64'(lo_o), 64'h1234);
        check("mthi_start_dropped", 64'(busy_o), 64'd0);

        // async reset at E20
        op_i = MD_DIVU; a_i = 32'd50; b_i = 32'd3; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        idle_cycles(20);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_hi_lo", {hi_o, lo_o}, 64'd0);
        check("arst_busy_done", {62'd0, busy_o, done_o}, 64'd0);
        idle_cycles(2);
        rst_ni = 1'b1;
        idle_cycles(40);
        check("arst_no_resume", 64'(busy_o), 64'd0);

        run_op(MD_DIVU, 32'd50, 32'd3, 32'd2, 32'd16, 0, 1);
        idle_cycles(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
